forward_ctrl: RTL

Hazard and forwarding controller for the 16-bit pipelined core. It tracks the destination registers of the instructions in EX, MEM and WB. From these it drives the 2-bit selects of the two 4:1 16-bit operand muxes in decode. It also generates the load-use stall and the taken-branch fetch flush. It sits beside the decode stage, between the register file read ports and the ID/EX pipeline register.

---
 rtl/forward_ctrl_pkg.sv | 19 +
 rtl/forward_ctrl_if.sv | 34 +++
 rtl/forward_ctrl_fwd_sel.sv | 47 ++++
 rtl/forward_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/forward_ctrl_pkg.sv
// Shared constants and types for the decode-stage hazard/forwarding controller.
package forward_ctrl_pkg;

  localparam int REG_ADDR_W_DFLT = 3;
  localparam int CNT_W_DFLT      = 16;

  // Operand mux select encodings
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2
  } state_t;

endpackage

// File: rtl/forward_ctrl_if.sv
// Decode-side bundle: instruction fields in, forwarding selects and pipeline control out.
interface forward_ctrl_if
  import forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT,
  parameter int CNT_W      = CNT_W_DFLT
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_wr;
  logic                  id_mem_rd;
  logic                  id_branch_taken;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  stall;
  logic                  flush_if;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_wr, id_mem_rd, id_branch_taken,
    input  fwd_a, fwd_b, stall, flush_if, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_wr, id_mem_rd, id_branch_taken,
    output fwd_a, fwd_b, stall, flush_if, stall_count
  );
endinterface

// File: rtl/forward_ctrl_fwd_sel.sv
// Per-operand forwarding select: youngest matching writer wins, a load still in EX
// cannot forward and is reported as a load-use hazard instead.
module fwd_sel
  import forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  src_used,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  ex_wr,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic                  mem_wr,
  input  logic [REG_ADDR_W-1:0] wb_dst,
  input  logic                  wb_wr,
  output logic [1:0]            sel,
  output logic                  load_haz
);

  logic live;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  // R0 is hardwired to zero, so it never needs forwarding
  assign live    = src_used && (src != '0);
  assign hit_ex  = live && ex_wr  && (ex_dst  == src);
  assign hit_mem = live && mem_wr && (mem_dst == src);
  assign hit_wb  = live && wb_wr  && (wb_dst  == src);

  // Priority select; a load in EX leaves the mux on the register file for the bubble cycle
  always_comb begin
    sel      = FWD_RF;
    load_haz = 1'b0;
    if (hit_ex && ex_load) begin
      load_haz = 1'b1;
    end else if (hit_ex) begin
      sel = FWD_EX;
    end else if (hit_mem) begin
      sel = FWD_MEM;
    end else if (hit_wb) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// Hazard and forwarding controller beside the decode stage.
//
//   state         | meaning
//   --------------+------------------------------------------------------
//   ST_RUN        | normal issue
//   ST_LOAD_STALL | one bubble was inserted; decode re-evaluates held instr
//   ST_FLUSH      | fetch after a taken branch was squashed; EX gets a bubble
module forward_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT,
  parameter int CNT_W      = CNT_W_DFLT
) (
  input logic          clk,
  input logic          reset,
  forward_ctrl_if.slave bus
);

  state_t state, state_nxt;

  // Shadow pipeline; only EX needs the load flag since only EX can cause a hazard
  logic [REG_ADDR_W-1:0] ex_dst, mem_dst, wb_dst;
  logic                  ex_wr, mem_wr, wb_wr;
  logic                  ex_load;

  logic [1:0]       sel_a, sel_b;
  logic             haz_a, haz_b;
  logic             hazard;
  logic             branch;
  logic [CNT_W-1:0] stall_cnt;

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .src      (bus.id_rs1),
    .src_used (bus.id_rs1_used),
    .ex_dst   (ex_dst),
    .ex_wr    (ex_wr),
    .ex_load  (ex_load),
    .mem_dst  (mem_dst),
    .mem_wr   (mem_wr),
    .wb_dst   (wb_dst),
    .wb_wr    (wb_wr),
    .sel      (sel_a),
    .load_haz (haz_a)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .src      (bus.id_rs2),
    .src_used (bus.id_rs2_used),
    .ex_dst   (ex_dst),
    .ex_wr    (ex_wr),
    .ex_load  (ex_load),
    .mem_dst  (mem_dst),
    .mem_wr   (mem_wr),
    .wb_dst   (wb_dst),
    .wb_wr    (wb_wr),
    .sel      (sel_b),
    .load_haz (haz_b)
  );

  assign hazard = bus.id_valid && (haz_a || haz_b);
  assign branch = bus.id_valid && bus.id_branch_taken;

  // Decode-cycle outputs; a stall defers the branch so it re-resolves with forwarded operands
  always_comb begin
    bus.stall    = hazard;
    bus.flush_if = branch && !hazard;
    bus.fwd_a    = bus.id_valid ? sel_a : FWD_RF;
    bus.fwd_b    = bus.id_valid ? sel_b : FWD_RF;
  end

  assign bus.stall_count = stall_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (hazard)      state_nxt = ST_LOAD_STALL;
        else if (branch) state_nxt = ST_FLUSH;
      end
      ST_LOAD_STALL: state_nxt = ST_RUN;
      ST_FLUSH:      state_nxt = ST_RUN;
      default:       state_nxt = ST_RUN;
    endcase
  end

  // Shadow pipeline advance; stalled, invalid or squashed decode slots enter EX as bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_dst  <= '0;
      ex_wr   <= 1'b0;
      ex_load <= 1'b0;
      mem_dst <= '0;
      mem_wr  <= 1'b0;
      wb_dst  <= '0;
      wb_wr   <= 1'b0;
    end else begin
      wb_dst  <= mem_dst;
      wb_wr   <= mem_wr;
      mem_dst <= ex_dst;
      mem_wr  <= ex_wr;
      if (bus.id_valid && !hazard && (state != ST_FLUSH)) begin
        ex_dst  <= bus.id_rd;
        ex_wr   <= bus.id_reg_wr;
        ex_load <= bus.id_mem_rd;
      end else begin
        ex_dst  <= '0;
        ex_wr   <= 1'b0;
        ex_load <= 1'b0;
      end
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
